nibble_serial_subtractor_ctrl: RTL and testbench



---
 rtl/subtractor_pkg.sv | 13 +
 rtl/ripple_borrow_adder_4_bit.sv | 27 ++
 rtl/nibble_serial_subtractor_ctrl.sv | 114 +++++++++++
 tb/tb_nibble_serial_subtractor_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: the FSM state encoding
// and the width of the time-shared datapath.
package subtractor_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_borrow_adder_4_bit.sv
// 4-bit ripple-borrow subtractor: diff = a - b - b_in, borrow = (a < b + b_in).
module ripple_borrow_adder_4_bit
  import subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                b_in,
  output logic [NIBBLE_W-1:0] diff,
  output logic                borrow
);

  logic [NIBBLE_W:0] brw;

  // Borrow ripples from bit 0 upward; brw[i] is the borrow into bit i.
  always_comb begin
    brw    = '0;
    diff   = '0;
    brw[0] = b_in;
    for (int i = 0; i < int'(NIBBLE_W); i++) begin
      diff[i]  = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
  end

  assign borrow = brw[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor_ctrl.sv
// Wide subtractor built by time-sharing one 4-bit ripple-borrow datapath,
// one nibble per clock, LSB nibble first, with the borrow chained through a register.
module nibble_serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                brw_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_d;
  logic                nib_bo;

  // Select the current nibble of each latched operand.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (idx == IDX_W'(k)) begin
        nib_a = a_q[k*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_borrow_adder_4_bit u_sub (
    .a      (nib_a),
    .b      (nib_b),
    .b_in   (brw_q),
    .diff   (nib_d),
    .borrow (nib_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      brw_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            brw_q  <= b_in;
            diff   <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          for (int k = 0; k < int'(NIBBLES); k++) begin
            if (idx == IDX_W'(k)) begin
              diff[k*NIBBLE_W +: NIBBLE_W] <= nib_d;
            end
          end
          brw_q <= nib_bo;
          // Last nibble: publish the borrow and stop idx short of wrapping.
          if (idx == LAST_IDX) begin
            borrow <= nib_bo;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor_ctrl.sv
// Bench for the nibble-serial subtractor: a 16-bit instance driven from a vector
// table and corner sequences, and a 4-bit instance swept over all inputs.
module tb_nibble_serial_subtractor_ctrl;

  localparam int unsigned N16 = 4;
  localparam int unsigned N4  = 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        b_in4;
  logic        busy4;
  logic        done4;
  logic [3:0]  diff4;
  logic        borrow4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] ed;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    int          due;
  } exp16_t;

  typedef struct {
    logic [3:0] d;
    logic       bo;
    int         due;
  } exp4_t;

  exp16_t q16[$];
  exp4_t  q4[$];
  vec_t   tbl[8];

  int checks;
  int errors;
  int cyc;

  nibble_serial_subtractor_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  nibble_serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .b_in(b_in4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample #1 after the edge and retire scoreboard entries on done.
  task automatic tick();
    exp16_t e16;
    exp4_t  e4;
    @(posedge clk);
    #1;
    cyc++;
    chk("busy_done_excl16", 32'(busy & done), 32'(0));
    chk("busy_done_excl4", 32'(busy4 & done4), 32'(0));
    if (done) begin
      if (q16.size() == 0) begin
        chk("unexpected_done16", 32'(done), 32'(0));
      end else begin
        e16 = q16.pop_front();
        chk("diff16", 32'(diff), 32'(e16.d));
        chk("borrow16", 32'(borrow), 32'(e16.bo));
        chk("latency16", 32'(cyc), 32'(e16.due));
      end
    end else if (q16.size() > 0 && cyc > q16[0].due) begin
      chk("timeout16_done", 32'(done), 32'(1));
      e16 = q16.pop_front();
    end
    if (done4) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'(done4), 32'(0));
      end else begin
        e4 = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(e4.d));
        chk("borrow4", 32'(borrow4), 32'(e4.bo));
        chk("latency4", 32'(cyc), 32'(e4.due));
      end
    end else if (q4.size() > 0 && cyc > q4[0].due) begin
      chk("timeout4_done", 32'(done4), 32'(1));
      e4 = q4.pop_front();
    end
  endtask

  task automatic push16(input logic [15:0] ed, input logic eb);
    q16.push_back('{d: ed, bo: eb, due: cyc + 1 + int'(N16)});
  endtask

  task automatic run_op16(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb);
    a = va; b = vb; b_in = vbin; start = 1'b1;
    push16(ed, eb);
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'(1));
    for (int k = 1; k < int'(N16); k++) begin
      tick();
      chk("busy_run", 32'(busy), 32'(1));
      chk("done_early", 32'(done), 32'(0));
    end
    tick();
    chk("busy_in_done", 32'(busy), 32'(0));
    chk("done_pulse", 32'(done), 32'(1));
    tick();
    chk("done_one_cycle", 32'(done), 32'(0));
  endtask

  task automatic run_op4(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                         input logic [3:0] ed, input logic eb);
    a4 = va; b4 = vb; b_in4 = vbin; start4 = 1'b1;
    q4.push_back('{d: ed, bo: eb, due: cyc + 1 + int'(N4)});
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    chk("busy4_run", 32'(busy4), 32'(1));
    tick();
    chk("busy4_in_done", 32'(busy4), 32'(0));
    tick();
  endtask

  initial begin
    logic [16:0] m;
    logic [4:0]  m5;
    logic [15:0] held_d;

    checks = 0; errors = 0; cyc = 0; held_d = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; b_in4 = 1'b0;

    tbl[0] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    tbl[1] = '{16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0};
    tbl[4] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0};
    tbl[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1};
    tbl[6] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
    tbl[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};

    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_borrow", 32'(borrow), 32'(0));
    chk("rst_busy4", 32'(busy4), 32'(0));
    chk("rst_diff4", 32'(diff4), 32'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op16(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].ed, tbl[i].eb);
    end

    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      m = {1'b0, ra} - {1'b0, rb} - 17'(rc);
      run_op16(ra, rb, rc, m[15:0], m[16]);
    end

    // start held for ten edges with fresh operands every cycle
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom); start = 1'b1;
      if (i == 0 || i == 6) begin
        m = {1'b0, a} - {1'b0, b} - 17'(b_in);
        push16(m[15:0], m[16]);
        if (i == 0) held_d = m[15:0];
      end
      tick();
      if (i == 5) begin
        chk("held_diff", 32'(diff), 32'(held_d));
        chk("held_idle_busy", 32'(busy), 32'(0));
      end
      if (i == 6) chk("second_accept_busy", 32'(busy), 32'(1));
    end
    start = 1'b0;
    repeat (6) tick();
    chk("held_queue_drained", 32'(q16.size()), 32'(0));

    // reset in the second RUN cycle, with start also high to test priority
    a = 16'h1234; b = 16'h0001; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("partial_diff", 32'(diff), 32'(16'h0003));
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_diff", 32'(diff), 32'(0));
    chk("abort_borrow", 32'(borrow), 32'(0));
    repeat (6) tick();
    run_op16(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          m5 = 5'(ia) - 5'(ib) - 5'(ic);
          run_op4(4'(ia), 4'(ib), 1'(ic), m5[3:0], m5[4]);
        end
      end
    end

    repeat (3) tick();
    chk("final_q16_empty", 32'(q16.size()), 32'(0));
    chk("final_q4_empty", 32'(q4.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
